// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/response bundle between the data-memory arbiter
// and its two requesters (m0 = core load/store, m1 = debug/loader).
//   mX_req/we/addr/wdata : request, held stable until mX_gnt
//   mX_gnt               : combinational grant, access happens at that edge
//   mX_rvalid/mX_rdata   : registered read response, one cycle after grant
//   ready                : memory clear finished, requests now served
//   conflict_cnt         : saturating count of contended cycles
// master = requester side, slave = arbiter side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;
    logic              m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic              ready;
    logic [15:0]       conflict_cnt;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ready, conflict_cnt
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ready, conflict_cnt
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: owns a DEPTH x DATA_W data memory shared by two requesters.
// After reset every word is zero-filled (one word per clock) before any
// request is served; afterwards one access per cycle is granted round-robin.
// Reads return registered data one cycle after the grant.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (restarts the clear sequence)
//   bus  - dmem_arbiter_if.slave: both requester ports, ready, conflict_cnt
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NPORT = 2;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                          state_q, state_d;
    logic [ADDR_W-1:0]               clr_ptr;
    logic                            last_gnt;
    logic [15:0]                     conflict_cnt;
    logic [NPORT-1:0]                req, we, gnt, rvalid;
    logic [NPORT-1:0][ADDR_W-1:0]    addr;
    logic [NPORT-1:0][DATA_W-1:0]    wdata, rdata;
    logic                            acc, acc_port, acc_we;
    logic [ADDR_W-1:0]               acc_addr;
    logic [DATA_W-1:0]               mem [DEPTH];

    assign req   = {bus.m1_req,   bus.m0_req};
    assign we    = {bus.m1_we,    bus.m0_we};
    assign addr  = {bus.m1_addr,  bus.m0_addr};
    assign wdata = {bus.m1_wdata, bus.m0_wdata};

    always_comb begin
        state_d = state_q;
        gnt     = '0;
        case (state_q)
            CLEAR: if (clr_ptr == ADDR_W'(DEPTH - 1)) state_d = RUN;
            RUN: begin
                // On a tie the port that did not win last time goes first.
                if (&req) gnt = last_gnt ? 2'b01 : 2'b10;
                else      gnt = req;
            end
            default: state_d = CLEAR;
        endcase
    end

    // At most one grant per cycle, so the memory needs a single port.
    assign acc      = |gnt;
    assign acc_port = gnt[1];
    assign acc_we   = we[acc_port];
    assign acc_addr = addr[acc_port];

    // Storage has no reset of its own; the clear sequence owns initialisation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR)  mem[clr_ptr]  <= '0;
            else if (acc && acc_we) mem[acc_addr] <= wdata[acc_port];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            clr_ptr      <= '0;
            last_gnt     <= 1'b1;
            rvalid       <= '0;
            rdata        <= '0;
            conflict_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) clr_ptr <= clr_ptr + 1'b1;
            if (acc) last_gnt <= acc_port;
            for (int p = 0; p < NPORT; p++) begin
                rvalid[p] <= gnt[p] & ~we[p];
                if (gnt[p] && !we[p]) rdata[p] <= mem[acc_addr];
            end
            if (state_q == RUN && (&req) && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    assign bus.m0_gnt       = gnt[0];
    assign bus.m1_gnt       = gnt[1];
    assign bus.m0_rvalid    = rvalid[0];
    assign bus.m1_rvalid    = rvalid[1];
    assign bus.m0_rdata     = rdata[0];
    assign bus.m1_rdata     = rdata[1];
    assign bus.ready        = (state_q == RUN);
    assign bus.conflict_cnt = conflict_cnt;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios with literal expectations followed by
// randomized traffic; a behavioural model of the arbiter is compared with
// the DUT on every falling edge.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) b ();
    dmem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (.clk(clk), .rst(rst), .bus(b));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] mem_m [0:255];
    bit          m_init  = 0;
    bit          m_ready = 0;
    int          m_clr   = 0;
    int          m_last  = 1;   // port that won the most recent grant
    logic [1:0]  m_rvalid = '0;
    logic [15:0] m_rdata [2];
    int          m_cnt   = 0;

    always @(negedge clk) begin
        logic [1:0]  eg;
        logic [1:0]  rq;
        int          w;
        rq = {b.m1_req, b.m0_req};
        eg = 2'b00;
        if (m_ready) begin
            if (rq == 2'b11) eg = (m_last == 0) ? 2'b10 : 2'b01;
            else             eg = rq;
        end
        if (m_init && !rst) begin
            check("gnt",          {b.m1_gnt, b.m0_gnt}, eg);
            check("ready",        b.ready, m_ready);
            check("m0_rvalid",    b.m0_rvalid, m_rvalid[0]);
            check("m1_rvalid",    b.m1_rvalid, m_rvalid[1]);
            check("m0_rdata",     b.m0_rdata, m_rdata[0]);
            check("m1_rdata",     b.m1_rdata, m_rdata[1]);
            check("conflict_cnt", b.conflict_cnt, m_cnt);
        end
        // advance model across the coming rising edge
        if (rst) begin
            m_init = 1; m_ready = 0; m_clr = 0; m_last = 1;
            m_rvalid = '0; m_rdata[0] = '0; m_rdata[1] = '0; m_cnt = 0;
        end else if (m_init) begin
            m_rvalid = '0;
            if (!m_ready) begin
                m_clr++;
                if (m_clr == 256) begin
                    m_ready = 1;
                    for (int i = 0; i < 256; i++) mem_m[i] = '0;
                end
            end else begin
                if (rq == 2'b11 && m_cnt < 65535) m_cnt++;
                if (eg != 2'b00) begin
                    w = eg[1] ? 1 : 0;
                    m_last = w;
                    if (w == 0) begin
                        if (b.m0_we) mem_m[b.m0_addr] = b.m0_wdata;
                        else begin m_rdata[0] = mem_m[b.m0_addr]; m_rvalid[0] = 1'b1; end
                    end else begin
                        if (b.m1_we) mem_m[b.m1_addr] = b.m1_wdata;
                        else begin m_rdata[1] = mem_m[b.m1_addr]; m_rvalid[1] = 1'b1; end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int bad_gnt;
        int r0, r1;
        logic [5:0] seq0, seq1;
        bit g0, g1;
        b.m0_req = 0; b.m0_we = 0; b.m0_addr = '0; b.m0_wdata = '0;
        b.m1_req = 0; b.m1_we = 0; b.m1_addr = '0; b.m1_wdata = '0;

        // reset then idle clear
        rst = 1;
        tick(); tick();
        check("rst_ready", b.ready, 0);
        check("rst_m0_rvalid", b.m0_rvalid, 0);
        check("rst_m0_rdata", b.m0_rdata, 0);
        check("rst_cnt", b.conflict_cnt, 0);
        rst = 0;
        repeat (255) tick();
        check("ready_at_255", b.ready, 0);
        tick();
        check("ready_at_256", b.ready, 1);

        // read of a cleared word
        b.m0_req = 1; b.m0_we = 0; b.m0_addr = 8'h37;
        settle();
        check("rd37_gnt", b.m0_gnt, 1);
        tick();
        b.m0_req = 0;
        check("rd37_rvalid", b.m0_rvalid, 1);
        check("rd37_rdata", b.m0_rdata, 16'h0000);

        // write then read same address
        b.m0_req = 1; b.m0_we = 1; b.m0_addr = 8'h10; b.m0_wdata = 16'hBEEF;
        tick();
        check("wr_no_rvalid", b.m0_rvalid, 0);
        b.m0_we = 0;
        tick();
        b.m0_req = 0;
        check("beef_rvalid", b.m0_rvalid, 1);
        check("beef_rdata", b.m0_rdata, 16'hBEEF);
        check("beef_m1_rvalid", b.m1_rvalid, 0);
        check("model_beef", m_rdata[0], 16'hBEEF);

        // cross-port coherence
        b.m1_req = 1; b.m1_we = 1; b.m1_addr = 8'hFF; b.m1_wdata = 16'h1234;
        tick();
        b.m1_req = 0;
        b.m0_req = 1; b.m0_we = 0; b.m0_addr = 8'hFF;
        tick();
        b.m0_req = 0;
        check("xport_rdata", b.m0_rdata, 16'h1234);

        // reset, both ports request reads during the clear
        rst = 1;
        tick();
        rst = 0;
        b.m0_req = 1; b.m0_we = 0; b.m0_addr = 8'h10;
        b.m1_req = 1; b.m1_we = 0; b.m1_addr = 8'hFF;
        bad_gnt = 0;
        for (int i = 0; i < 256; i++) begin
            settle();
            if (b.m0_gnt || b.m1_gnt) bad_gnt++;
            tick();
        end
        check("clear_no_gnt", bad_gnt, 0);
        settle();
        check("clear_done_ready", b.ready, 1);
        check("first_run_gnt", {b.m1_gnt, b.m0_gnt}, 2'b01);
        seq0 = '0; seq1 = '0; r0 = 0; r1 = 0;
        for (int i = 0; i < 6; i++) begin
            settle();
            seq0 = {seq0[4:0], b.m0_gnt};
            seq1 = {seq1[4:0], b.m1_gnt};
            tick();
            r0 += int'(b.m0_rvalid);
            r1 += int'(b.m1_rvalid);
        end
        b.m0_req = 0; b.m1_req = 0;
        check("rr_seq_m0", seq0, 6'b101010);
        check("rr_seq_m1", seq1, 6'b010101);
        check("rr_cnt", b.conflict_cnt, 6);
        check("model_cnt", m_cnt, 6);
        check("rr_m0_pulses", r0, 3);
        check("rr_m1_pulses", r1, 3);
        check("reclr_m0_rdata", b.m0_rdata, 16'h0000);
        check("reclr_m1_rdata", b.m1_rdata, 16'h0000);

        // reset right after a read grant
        b.m0_req = 1; b.m0_we = 0; b.m0_addr = 8'h10;
        tick();
        b.m0_req = 0;
        rst = 1;
        tick();
        check("midrst_rvalid", b.m0_rvalid, 0);
        check("midrst_ready", b.ready, 0);
        check("midrst_cnt", b.conflict_cnt, 0);
        rst = 0;
        repeat (256) tick();

        // randomized traffic, handshake honoured (hold until granted)
        g0 = 0; g1 = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!b.m0_req || g0) begin
                b.m0_req   = ($urandom_range(0, 3) != 0);
                b.m0_we    = 1'($urandom_range(0, 1));
                b.m0_addr  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
                b.m0_wdata = 16'($urandom);
            end
            if (!b.m1_req || g1) begin
                b.m1_req   = ($urandom_range(0, 3) != 0);
                b.m1_we    = 1'($urandom_range(0, 1));
                b.m1_addr  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
                b.m1_wdata = 16'($urandom);
            end
            settle();
            g0 = b.m0_gnt;
            g1 = b.m1_gnt;
            tick();
        end
        b.m0_req = 0; b.m1_req = 0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
